// File: rtl/result_writeback_if.sv
// Record bus between the collision control unit and the writeback stage,
// plus the single-port output-memory write port driven by the writeback stage.
interface result_writeback_if;
  logic        weout;
  logic [31:0] addressout;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] in3;
  logic [31:0] in4;
  logic [31:0] in5;
  logic [31:0] in6;
  logic [31:0] in7;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;

  // Control-unit side: presents records, observes the memory port.
  modport master (
    output weout, addressout, in0, in1, in2, in3, in4, in5, in6, in7,
    input  mem_addr, mem_data, mem_we
  );

  // Writeback side: consumes records, drives the memory port.
  modport slave (
    input  weout, addressout, in0, in1, in2, in3, in4, in5, in6, in7,
    output mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/result_writeback.sv
// result_writeback: captures an eight-word result record on the rising edge of
// the control unit's write strobe, range-checks its base address and streams
// the words into the output memory one per cycle. Keeps sticky error flags and
// a saturating record counter. All outputs are registered, so every memory
// write and status change appears one cycle after the FSM state that causes it.
module result_writeback #(
  parameter int DEPTH = 64
) (
  input  logic               clk,
  input  logic               rstmaster,
  result_writeback_if.slave  bus,
  output logic               busy,
  output logic               wb_done,
  output logic [15:0]        rec_count,
  output logic               range_err,
  output logic               drop_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Highest legal address of the last word, widened to match the 33-bit sum.
  localparam logic [32:0] LP_LAST = 33'(DEPTH - 1);

  logic [1:0]  r_state;
  logic        r_weout_d;
  logic [31:0] r_buf [8];
  logic [31:0] r_base;
  logic [2:0]  r_idx;
  logic        r_reject_pend;

  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;
  logic        r_mem_we;
  logic        r_busy;
  logic        r_wb_done;
  logic [15:0] r_rec_count;
  logic        r_range_err;
  logic        r_drop_err;

  logic        w_edge;
  logic        w_accept;
  logic [32:0] w_last;
  logic [31:0] w_in [8];

  assign w_in[0] = bus.in0;
  assign w_in[1] = bus.in1;
  assign w_in[2] = bus.in2;
  assign w_in[3] = bus.in3;
  assign w_in[4] = bus.in4;
  assign w_in[5] = bus.in5;
  assign w_in[6] = bus.in6;
  assign w_in[7] = bus.in7;

  // Strobe edge detect and range check; the last-word address is summed at
  // 33 bits so a base near the top of the 32-bit range cannot wrap to a
  // small, apparently legal value.
  always_comb begin
    w_edge = bus.weout & ~r_weout_d;
    w_last = {1'b0, bus.addressout} + 33'd7;
    if (!bus.addressout[31] && (w_last <= LP_LAST)) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
  end

  // Record FSM: capture on an accepted edge, step through the eight words,
  // then one completion cycle. A rejected edge only flags a pending error.
  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      r_state       <= S_IDLE;
      r_weout_d     <= 1'b1;
      r_base        <= 32'd0;
      r_idx         <= 3'd0;
      r_reject_pend <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_buf[i] <= 32'd0;
      end
    end else begin
      r_weout_d     <= bus.weout;
      r_reject_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            if (w_accept) begin
              r_base  <= bus.addressout;
              r_idx   <= 3'd0;
              r_state <= S_WRITE;
              for (int i = 0; i < 8; i++) begin
                r_buf[i] <= w_in[i];
              end
            end else begin
              r_reject_pend <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (r_idx == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered outputs derived from the current FSM state, plus the sticky
  // flags and the saturating counter (bumped the cycle after wb_done).
  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      r_mem_addr  <= 32'd0;
      r_mem_data  <= 32'd0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_wb_done   <= 1'b0;
      r_rec_count <= 16'd0;
      r_range_err <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_wb_done   <= 1'b0;
      r_busy      <= (r_state != S_IDLE);
      r_range_err <= r_range_err | r_reject_pend;
      if (r_wb_done && (r_rec_count != 16'hFFFF)) begin
        r_rec_count <= r_rec_count + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          r_mem_we <= 1'b0;
        end
        S_WRITE: begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= r_base + {29'd0, r_idx};
          r_mem_data <= r_buf[r_idx];
          if (w_edge) begin
            r_drop_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_wb_done <= 1'b1;
          if (w_edge) begin
            r_drop_err <= 1'b1;
          end
        end
        default: begin
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign bus.mem_we   = r_mem_we;
  assign busy         = r_busy;
  assign wb_done      = r_wb_done;
  assign rec_count    = r_rec_count;
  assign range_err    = r_range_err;
  assign drop_err     = r_drop_err;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: stimulus pushes expected memory writes and
// completions (with their cycle numbers) into queues; a negedge monitor pops
// and compares whenever the DUT writes memory or pulses wb_done.
module tb_result_writeback;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } dn_t;

  logic        clk = 1'b0;
  logic        rstmaster;
  logic        busy;
  logic        wb_done;
  logic [15:0] rec_count;
  logic        range_err;
  logic        drop_err;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  wr_t         exp_wr[$];
  dn_t         exp_dn[$];

  result_writeback_if bus ();

  result_writeback #(.DEPTH(64)) dut (
    .clk       (clk),
    .rstmaster (rstmaster),
    .bus       (bus),
    .busy      (busy),
    .wb_done   (wb_done),
    .rec_count (rec_count),
    .range_err (range_err),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every memory write and completion against the queues.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_mem_we", {31'd0, bus.mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_data, e.data);
      end
    end
    if (wb_done === 1'b1) begin
      if (exp_dn.size() == 0) begin
        chk("unexpected_wb_done", {31'd0, wb_done}, 32'd0);
      end else begin
        dn_t d;
        d = exp_dn.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("done_count", {16'd0, rec_count}, {16'd0, d.cnt});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_in(input logic [31:0] d0);
    bus.in0 = d0;
    bus.in1 = d0 + 32'd1;
    bus.in2 = d0 + 32'd2;
    bus.in3 = d0 + 32'd3;
    bus.in4 = d0 + 32'd4;
    bus.in5 = d0 + 32'd5;
    bus.in6 = d0 + 32'd6;
    bus.in7 = d0 + 32'd7;
  endtask

  // Present a record and raise the strobe; n is the sampling edge number.
  // nwr is how many writes are expected (8 = full record, 0 = rejected).
  task automatic issue(input logic [31:0] addr, input logic [31:0] d0,
                       input int nwr, output int n);
    tick();
    bus.weout      = 1'b0;
    bus.addressout = addr;
    set_in(d0);
    tick();
    bus.weout = 1'b1;
    n = cyc + 1;
    for (int k = 0; k < nwr; k++) begin
      wr_t e;
      e.cyc  = n + 1 + k;
      e.addr = addr + 32'(k);
      e.data = d0 + 32'(k);
      exp_wr.push_back(e);
    end
    if (nwr == 8) begin
      dn_t d;
      d.cyc = n + 9;
      d.cnt = 16'(exp_cnt);
      exp_dn.push_back(d);
      exp_cnt++;
    end
  endtask

  initial begin
    int n;
    rstmaster      = 1'b0;
    bus.weout      = 1'b1;
    bus.addressout = 32'hFFFF_FFF9;
    set_in(32'd0);
    #1;
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, rec_count}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    tick(); tick(); tick();
    rstmaster = 1'b1;
    // Strobe held high across release: must not be a request.
    repeat (12) tick();
    chk("held_range_err", {31'd0, range_err}, 32'd0);
    chk("held_drop_err", {31'd0, drop_err}, 32'd0);
    chk("held_count", {16'd0, rec_count}, 32'd0);

    // Base 8, words 0x100..0x107.
    issue(32'd8, 32'h100, 8, n);
    wait_until(n);
    chk("a_busy_N", {31'd0, busy}, 32'd0);
    wait_until(n + 1);
    chk("a_busy_N1", {31'd0, busy}, 32'd1);
    wait_until(n + 9);
    chk("a_busy_N9", {31'd0, busy}, 32'd1);
    chk("a_count_N9", {16'd0, rec_count}, 32'd0);
    wait_until(n + 10);
    chk("a_busy_N10", {31'd0, busy}, 32'd0);
    chk("a_count_N10", {16'd0, rec_count}, 32'd1);

    // Power-up address -7: rejected, range_err from N+1.
    issue(32'hFFFF_FFF9, 32'h0, 0, n);
    wait_until(n);
    chk("neg_range_N", {31'd0, range_err}, 32'd0);
    wait_until(n + 1);
    chk("neg_range_N1", {31'd1, range_err} & 32'd1, 32'd1);
    chk("neg_busy_N1", {31'd0, busy}, 32'd0);
    wait_until(n + 12);
    chk("neg_count", {16'd0, rec_count}, 32'd1);

    // Base 57: last word would be 64, rejected.
    issue(32'd57, 32'hDEAD_0000, 0, n);
    wait_until(n + 12);
    chk("b57_count", {16'd0, rec_count}, 32'd1);

    // Base 56: accepted, last word lands at 63.
    issue(32'd56, 32'h200, 8, n);
    wait_until(n + 12);
    chk("b56_count", {16'd0, rec_count}, 32'd2);

    // Base near 2^31: must not wrap into range.
    issue(32'h7FFF_FFFC, 32'hBEEF_0000, 0, n);
    wait_until(n + 12);
    chk("wrap_range", {31'd0, range_err}, 32'd1);
    chk("wrap_count", {16'd0, rec_count}, 32'd2);
    chk("pre_drop_err", {31'd0, drop_err}, 32'd0);

    // Base 0: inputs change right after capture; second edge at N+4 dropped.
    issue(32'd0, 32'h300, 8, n);
    wait_until(n);
    set_in(32'd0);
    bus.addressout = 32'd20;
    wait_until(n + 2);
    bus.weout = 1'b0;
    wait_until(n + 3);
    bus.weout = 1'b1;
    wait_until(n + 5);
    chk("drop_err_set", {31'd0, drop_err}, 32'd1);
    wait_until(n + 12);
    chk("drop_count", {16'd0, rec_count}, 32'd3);
    chk("drop_busy", {31'd0, busy}, 32'd0);

    // Base 16, reset asserted at N+3: only two words written, all cleared.
    issue(32'd16, 32'h400, 2, n);
    wait_until(n + 3);
    rstmaster = 1'b0;
    exp_cnt   = 0;
    #1;
    chk("mid_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {16'd0, rec_count}, 32'd0);
    chk("mid_rst_range", {31'd0, range_err}, 32'd0);
    chk("mid_rst_drop", {31'd0, drop_err}, 32'd0);
    chk("mid_rst_done", {31'd0, wb_done}, 32'd0);
    chk("mid_rst_data", bus.mem_data, 32'd0);
    tick(); tick();
    rstmaster = 1'b1;
    repeat (3) tick();

    // Fresh record after reset: base 40, words 0x500..0x507.
    issue(32'd40, 32'h500, 8, n);
    wait_until(n + 12);
    chk("post_rst_count", {16'd0, rec_count}, 32'd1);
    chk("post_rst_range", {31'd0, range_err}, 32'd0);

    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_dn.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream stage of the collision control unit: captures the eight 32-bit result words it presents together with the output-memory address on each write strobe, and writes them one word per cycle into the single-port output memory. It range-checks each record, keeps sticky error flags and a record counter, and reports completion to the host side.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words in the output memory; valid addresses 0..DEPTH-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rstmaster  in  1  reset, asynchronous, active-low.
- weout  in  1  write strobe level from the control unit; a record is requested on its 0->1 transition.
- addressout  in  32  signed base word address of the record.
- in0..in7  in  32 each  result words, word k to be written at base+k.
- mem_addr  out  32  output-memory word address.
- mem_data  out  32  output-memory write data.
- mem_we  out  1  output-memory write enable; one word written per cycle it is high.
- busy  out  1  high while a record is being written or completed.
- wb_done  out  1  one-cycle pulse after the last word of an accepted record is written.
- rec_count  out  16  number of records written since reset; saturates at 16'hFFFF.
- range_err  out  1  sticky: a record was rejected for an out-of-range address.
- drop_err  out  1  sticky: a strobe edge arrived while busy and was ignored.

## Operation
- Reset (rstmaster low, takes effect immediately): state IDLE; mem_addr=0, mem_data=0, mem_we=0, busy=0, wb_done=0, rec_count=0, range_err=0, drop_err=0; internal weout_d=1, so a strobe already high when reset releases is not an edge.
- Edge detect: edge = weout & ~weout_d; weout_d <= weout every cycle. A held-high strobe produces exactly one request.
- IDLE: on edge, evaluate base = addressout as signed.
  - Accept if 0 <= base and base+7 <= DEPTH-1. Compute the base+7 sum at 33 bits, so no wrap to a small value. Latch in0..in7 and base into a record buffer, go WRITE with index=0.
  - Otherwise, set range_err, write nothing, no wb_done, stay IDLE. This includes the control unit's power-up address of -7.
- WRITE: mem_we=1, mem_addr=base+index, mem_data=buffer[index]; index increments each cycle. After index 7, go DONE.
- DONE: mem_we=0, wb_done=1 for one cycle, rec_count+1 (saturating); go IDLE.
- Edges seen in WRITE or DONE set drop_err and are otherwise ignored; no queuing.
- Inputs in0..in7 and addressout may change after the capture edge without affecting the record in flight.
- range_err and drop_err clear only on reset.

## Timing
- Edge sampled at clock edge N. The record is latched at N.
- mem_we is high for cycles N+1..N+8, addresses base..base+7 in order, data in0..in7 as latched at N.
- wb_done pulses in cycle N+9, and rec_count reflects the new value from N+10.
- busy is high N+1..N+9.
- IDLE again from N+10; the earliest next accepted edge is sampled at N+10.
- Rejected record: range_err is high from N+1; busy stays 0.
- All outputs are registered; no combinational input-to-output path.
- Reset asserted mid-WRITE: the write is abandoned on the next reset state, with no further mem_we; the partial record stays in memory and is not counted.

## Test plan
- Reset then weout held 1 across release -> no mem_we, no errors; weout 0 then 1 with base 8, in_k=32'h100+k -> mem_we cycles N+1..N+8 at addr 8..15, data 32'h100..32'h107; wb_done at N+9; rec_count=1.
- Edge with addressout=-7 -> range_err=1, no mem_we, rec_count unchanged. Edge with base 57 (DEPTH=64, 57+7=64) -> rejected. Edge with base 56 -> accepted, last addr 63.
- Edge with base 32'h7FFFFFFC -> rejected (no 32-bit wrap); range_err=1.
- Second edge at N+4 during WRITE -> drop_err=1; first record completes unchanged; only one wb_done.
- Change in0..in7 to 0 at N+1 -> memory still receives the data latched at N.
- rstmaster low at N+3 -> mem_we=0 immediately, all outputs at reset values, rec_count=0. After release, a fresh edge writes a full record normally.
